// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet framer: FSM state encoding,
// default start-of-packet marker and the running checksum fold.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StSendHdr,
        StSendLen,
        StSendPay,
        StSendCsum
    } state_e;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/pkt_buffer.sv
// Payload store for one packet: Depth x 8 register array with an indexed
// write port and an asynchronous indexed read port.
module pkt_buffer #(
    parameter int unsigned Depth = 16,
    parameter int unsigned IdxW  = 5
) (
    input  logic            clk_i,
    input  logic            wr_en_i,
    input  logic [IdxW-1:0] wr_idx_i,
    input  logic [7:0]      wr_data_i,
    input  logic [IdxW-1:0] rd_idx_i,
    output logic [7:0]      rd_data_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

    logic [7:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i && (wr_idx_i <= LastIdx)) begin
            mem_q[wr_idx_i[AddrW-1:0]] <= wr_data_i;
        end
    end

    // The framer prefetches one slot past the last payload byte; return 0 there.
    always_comb begin
        rd_data_o = 8'h00;
        if (rd_idx_i <= LastIdx) begin
            rd_data_o = mem_q[rd_idx_i[AddrW-1:0]];
        end
    end

endmodule

// File: rtl/uart_pkt_framer.sv
// Groups FIFO payload bytes into packets and streams [HDR, LEN, payload, CSUM]
// to the UART transmitter over a registered valid/ready byte interface.
module uart_pkt_framer
    import uart_pkt_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD  = 16,
    parameter int unsigned IDLE_TIMEOUT = 32,
    parameter logic [7:0]  HDR_BYTE     = HDR_BYTE_DEFAULT,
    parameter int unsigned CNT_W        = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_dout_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       pkt_done,
    output logic       busy
);

    localparam int unsigned TMR_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PAYLOAD);
    localparam logic [TMR_W-1:0] TmoCnt = TMR_W'(IDLE_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pay_idx_q, pay_idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             rd_pending_q, rd_pending_d;
    logic             fifo_rd_en_q, fifo_rd_en_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             pkt_done_q, pkt_done_d;
    logic             busy_q, busy_d;

    logic             buf_wr_en;
    logic [CNT_W-1:0] buf_rd_idx;
    logic [7:0]       buf_rd_data;

    logic             tx_fire;
    logic             close_pkt;
    logic             rd_req;

    assign tx_fire   = tx_valid_q & tx_ready;
    // A packet never closes with a read in flight, so no fetched byte is dropped.
    assign close_pkt = !rd_pending_q &&
                       ((count_q == MaxCnt) || ((timer_q == TmoCnt) && (count_q != '0)));
    assign rd_req    = !fifo_empty && !rd_pending_q &&
                       ((count_q + CNT_W'(rd_pending_q)) < MaxCnt) && !close_pkt;

    pkt_buffer #(
        .Depth (MAX_PAYLOAD),
        .IdxW  (CNT_W)
    ) u_pkt_buffer (
        .clk_i     (clk),
        .wr_en_i   (buf_wr_en),
        .wr_idx_i  (count_q),
        .wr_data_i (fifo_dout),
        .rd_idx_i  (buf_rd_idx),
        .rd_data_o (buf_rd_data)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pay_idx_d    = pay_idx_q;
        csum_d       = csum_q;
        timer_d      = timer_q;
        rd_pending_d = rd_pending_q;
        fifo_rd_en_d = 1'b0;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        pkt_done_d   = 1'b0;
        buf_wr_en    = 1'b0;
        buf_rd_idx   = '0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d      = StCollect;
                    fifo_rd_en_d = 1'b1;
                    rd_pending_d = 1'b1;
                end
            end
            StCollect: begin
                if (fifo_dout_valid) begin
                    buf_wr_en    = 1'b1;
                    count_d      = count_q + CNT_W'(1);
                    csum_d       = csum_fold(csum_q, fifo_dout);
                    timer_d      = '0;
                    rd_pending_d = 1'b0;
                end else if (fifo_empty && !rd_pending_q && (timer_q != TmoCnt)) begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (close_pkt) begin
                    state_d    = StSendHdr;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HDR_BYTE;
                    timer_d    = '0;
                end else if (rd_req) begin
                    fifo_rd_en_d = 1'b1;
                    rd_pending_d = 1'b1;
                end
            end
            StSendHdr: begin
                if (tx_fire) begin
                    state_d   = StSendLen;
                    tx_data_d = 8'(count_q);
                end
            end
            StSendLen: begin
                if (tx_fire) begin
                    state_d   = StSendPay;
                    pay_idx_d = '0;
                    tx_data_d = buf_rd_data;
                end
            end
            StSendPay: begin
                // Prefetch the next payload byte so tx_data can be reloaded on the transfer edge.
                buf_rd_idx = pay_idx_q + CNT_W'(1);
                if (tx_fire) begin
                    if ((pay_idx_q + CNT_W'(1)) == count_q) begin
                        state_d   = StSendCsum;
                        tx_data_d = csum_fold(csum_q, 8'(count_q));
                    end else begin
                        pay_idx_d = pay_idx_q + CNT_W'(1);
                        tx_data_d = buf_rd_data;
                    end
                end
            end
            StSendCsum: begin
                if (tx_fire) begin
                    state_d    = StIdle;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    pkt_done_d = 1'b1;
                    count_d    = '0;
                    pay_idx_d  = '0;
                    csum_d     = 8'h00;
                    timer_d    = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            count_q      <= '0;
            pay_idx_q    <= '0;
            csum_q       <= 8'h00;
            timer_q      <= '0;
            rd_pending_q <= 1'b0;
            fifo_rd_en_q <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            pkt_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            pay_idx_q    <= pay_idx_d;
            csum_q       <= csum_d;
            timer_q      <= timer_d;
            rd_pending_q <= rd_pending_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            pkt_done_q   <= pkt_done_d;
            busy_q       <= busy_d;
        end
    end

    assign fifo_rd_en = fifo_rd_en_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign pkt_done   = pkt_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_pkt_framer.sv
// Directed bench for uart_pkt_framer: table of preloaded-FIFO packets plus
// hand-written trickle-timing and mid-frame reset sequences.
module tb_uart_pkt_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_dout_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       pkt_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_pkt_framer dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_empty      (fifo_empty),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_dout       (fifo_dout),
        .fifo_dout_valid (fifo_dout_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .pkt_done        (pkt_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: registered read, data valid the cycle after fifo_rd_en.
    logic [7:0] fifo_mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        fifo_dout_valid <= fifo_rd_en && !fifo_empty;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fifo_mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // UART side: always ready, or ready one cycle in three.
    int rdy_mode = 0;
    int rcyc = 0;
    always @(posedge clk) begin
        #2;
        rcyc++;
        tx_ready = (rdy_mode == 0) || ((rcyc % 3) == 0);
    end

    // Monitor: capture transfers, count pkt_done, check invariants every cycle.
    logic [7:0] rx_q [$];
    int         done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (pkt_done) done_cnt++;
            if (prev_stall) begin
                checks++;
                if (!tx_valid || (tx_data != prev_data)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%02h, required valid=1 data=%02h",
                             tx_valid, tx_data, prev_data);
                end
            end
            checks++;
            if (fifo_rd_en && fifo_empty) begin
                errors++;
                $display("FAIL rd_while_empty: got rd_en=1 with empty=1, required rd_en=0");
            end
            checks++;
            if (fifo_rd_en && fifo_dout_valid) begin
                errors++;
                $display("FAIL two_outstanding: got rd_en=1 while read data returning, required 0");
            end
        end
        prev_stall = !rst && tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst tx_valid", int'(tx_valid), 0);
        chk("rst tx_data", int'(tx_data), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst pkt_done", int'(pkt_done), 0);
        chk("rst fifo_rd_en", int'(fifo_rd_en), 0);
        rst = 1'b0;
        rx_q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            step();
            if ((done_cnt >= n) && !busy) break;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames, required %0d", done_cnt, n);
        end
        repeat (6) step();
    endtask

    task automatic compare_rx(input string nm, input int n_exp, input logic [31:0][7:0] exp,
                              input int n_frames);
        int got;
        chk({nm, " len"}, rx_q.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            got = (i < rx_q.size()) ? int'(rx_q[i]) : -1;
            chk($sformatf("%s byte%0d", nm, i), got, int'(exp[i]));
        end
        chk({nm, " frames"}, done_cnt, n_frames);
    endtask

    typedef struct packed {
        logic [7:0]       n_in;
        logic [31:0][7:0] din;
        logic             rdy;
        logic [7:0]       n_exp;
        logic [31:0][7:0] exp;
        logic [7:0]       n_frames;
    } vec_t;

    vec_t vecs [5];
    logic [31:0][7:0] e;
    int k;

    initial begin
        for (int v = 0; v < 5; v++) vecs[v] = '0;
        // 3 bytes, always ready: csum = 03^11^22^33 = 03
        vecs[0].n_in = 3;
        vecs[0].din[0] = 8'h11; vecs[0].din[1] = 8'h22; vecs[0].din[2] = 8'h33;
        vecs[0].n_exp = 6;
        vecs[0].exp[0] = 8'hA5; vecs[0].exp[1] = 8'h03; vecs[0].exp[2] = 8'h11;
        vecs[0].exp[3] = 8'h22; vecs[0].exp[4] = 8'h33; vecs[0].exp[5] = 8'h03;
        vecs[0].n_frames = 1;
        // 20 bytes 00..13: full packet (csum 10) then 4-byte packet (csum 04)
        vecs[1].n_in = 20;
        for (int i = 0; i < 20; i++) vecs[1].din[i] = 8'(i);
        vecs[1].exp[0] = 8'hA5; vecs[1].exp[1] = 8'h10;
        for (int i = 0; i < 16; i++) vecs[1].exp[2+i] = 8'(i);
        vecs[1].exp[18] = 8'h10;
        vecs[1].exp[19] = 8'hA5; vecs[1].exp[20] = 8'h04;
        vecs[1].exp[21] = 8'h10; vecs[1].exp[22] = 8'h11;
        vecs[1].exp[23] = 8'h12; vecs[1].exp[24] = 8'h13;
        vecs[1].exp[25] = 8'h04;
        vecs[1].n_exp = 26;
        vecs[1].n_frames = 2;
        // same as vector 0 with a stalling transmitter
        vecs[2] = vecs[0];
        vecs[2].rdy = 1'b1;
        // single byte FF: csum = 01^FF = FE
        vecs[3].n_in = 1;
        vecs[3].din[0] = 8'hFF;
        vecs[3].n_exp = 4;
        vecs[3].exp[0] = 8'hA5; vecs[3].exp[1] = 8'h01;
        vecs[3].exp[2] = 8'hFF; vecs[3].exp[3] = 8'hFE;
        vecs[3].n_frames = 1;
        // exactly 16 bytes 80..8F, stalled: payload xor 00, csum 10
        vecs[4].n_in = 16;
        for (int i = 0; i < 16; i++) vecs[4].din[i] = 8'h80 + 8'(i);
        vecs[4].rdy = 1'b1;
        vecs[4].exp[0] = 8'hA5; vecs[4].exp[1] = 8'h10;
        for (int i = 0; i < 16; i++) vecs[4].exp[2+i] = 8'h80 + 8'(i);
        vecs[4].exp[18] = 8'h10;
        vecs[4].n_exp = 19;
        vecs[4].n_frames = 1;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            rdy_mode = int'(vecs[v].rdy);
            for (int i = 0; i < int'(vecs[v].n_in); i++) push(vecs[v].din[i]);
            wait_frames(int'(vecs[v].n_frames), 3000);
            compare_rx($sformatf("vec%0d", v), int'(vecs[v].n_exp), vecs[v].exp,
                       int'(vecs[v].n_frames));
        end
        rdy_mode = 0;

        // Trickle with 31 empty cycles between bytes: timer never expires, closes at 16.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            push(8'h20 + 8'(i));
            repeat (34) step();
        end
        wait_frames(2, 3000);
        e = '0;
        e[0] = 8'hA5; e[1] = 8'h10;
        for (int i = 0; i < 16; i++) e[2+i] = 8'h20 + 8'(i);
        e[18] = 8'h10;
        e[19] = 8'hA5; e[20] = 8'h02; e[21] = 8'h30; e[22] = 8'h31; e[23] = 8'h03;
        compare_rx("trickle31", 24, e, 2);

        // Gap long enough for the timeout: each byte gets its own packet.
        do_reset();
        push(8'h40);
        repeat (36) step();
        push(8'h41);
        wait_frames(2, 3000);
        e = '0;
        e[0] = 8'hA5; e[1] = 8'h01; e[2] = 8'h40; e[3] = 8'h41;
        e[4] = 8'hA5; e[5] = 8'h01; e[6] = 8'h41; e[7] = 8'h40;
        compare_rx("gap_timeout", 8, e, 2);

        // One-cycle reset while payload bytes are streaming.
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        for (k = 0; k < 2000; k++) begin
            step();
            if (rx_q.size() >= 4) break;
        end
        chk("mid_pay reached", int'(k < 2000), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst tx_valid", int'(tx_valid), 0);
        chk("mid_rst busy", int'(busy), 0);
        chk("mid_rst pkt_done", int'(pkt_done), 0);
        rx_q.delete();
        done_cnt = 0;
        repeat (40) step();
        chk("mid_rst no_frame", done_cnt, 0);
        chk("mid_rst no_bytes", rx_q.size(), 0);
        push(8'h55);
        wait_frames(1, 3000);
        e = '0;
        e[0] = 8'hA5; e[1] = 8'h01; e[2] = 8'h55; e[3] = 8'h54;
        compare_rx("post_rst", 4, e, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
